// File: rtl/bot_evt_pkg.sv
// -----------------------------------------------------------------------------
// bot_evt_pkg
// Shared definitions for the bot_evt_sync event latch:
//   MAX_CH     - largest supported channel count
//   MAX_CNT_W  - widest overflow counter sat_inc() can handle
//   evt_cmd_e  - per-channel action chosen each cycle from (event, pending, ack)
//   sat_inc()  - saturating increment of a counter of run-time width
// -----------------------------------------------------------------------------
package bot_evt_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_CNT_W = 32;

    // EV_SET: capture data and (re)arm pending
    // EV_OVF: event lost because the channel is already pending
    // EV_CLR: acknowledge without a new event
    typedef enum logic [1:0] {
        EV_NONE,
        EV_SET,
        EV_OVF,
        EV_CLR
    } evt_cmd_e;

    // Increment cnt, holding at 2**width - 1. Bits of cnt above width are
    // expected to be zero.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] cnt,
        input int                   width
    );
        logic [MAX_CNT_W:0]   max_val;
        logic [MAX_CNT_W-1:0] result;
        max_val = ((MAX_CNT_W+1)'(1) << width) - (MAX_CNT_W+1)'(1);
        if ({1'b0, cnt} >= max_val) begin
            result = cnt;
        end else begin
            result = cnt + MAX_CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/bot_evt_channel.sv
// -----------------------------------------------------------------------------
// bot_evt_channel
// One event channel: synchroniser, edge/level event detect, pending flag,
// data snapshot and saturating overflow counter.
//   clk, rst     - clock, synchronous active-high reset
//   i_evt        - update strobe / level from the producer (may be async)
//   i_data       - data word captured when an event is accepted
//   i_ack        - write-1-to-clear of the pending flag
//   i_ovf_clr    - clear of the overflow counter
//   o_pending    - registered pending flag
//   o_snap       - registered snapshot of i_data
//   o_ovf_cnt    - events lost while pending (saturating)
// -----------------------------------------------------------------------------
module bot_evt_channel
    import bot_evt_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_evt,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ack,
    input  logic              i_ovf_clr,
    output logic              o_pending,
    output logic [DATA_W-1:0] o_snap,
    output logic [CNT_W-1:0]  o_ovf_cnt
);

    logic evt_s;
    logic ev;

    // ---------------------------------------------------------------- sync
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

            // NOTE: clocked state is always written with <= so every flop
            // samples the pre-edge value of the others; blocking assignments
            // here would collapse the synchroniser chain into one stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= SYNC_STAGES'({sync_q, i_evt});
                end
            end

            assign evt_s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign evt_s = i_evt;
        end
    endgenerate

    // --------------------------------------------------------- event detect
    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic                 evt_d_q;
            // Fills with ones after reset; the top bit says evt_d_q holds a
            // genuine post-reset sample. Until then the zeros in the sync
            // chain are reset values, not observed lows, so a level held
            // through reset must not look like a rising edge.
            logic [SYNC_STAGES:0] warm_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    evt_d_q <= 1'b0;
                    warm_q  <= '0;
                end else begin
                    evt_d_q <= evt_s;
                    warm_q  <= (SYNC_STAGES+1)'({warm_q, 1'b1});
                end
            end

            assign ev = evt_s & ~evt_d_q & warm_q[SYNC_STAGES];
        end else begin : g_level
            assign ev = evt_s;
        end
    endgenerate

    // ------------------------------------------------------ priority decode
    evt_cmd_e          cmd;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch forms.
    always_comb begin
        cmd = EV_NONE;
        if (ev && (!pending_q || i_ack)) begin
            cmd = EV_SET;          // event + ack re-arms, not an overflow
        end else if (ev) begin
            cmd = EV_OVF;
        end else if (i_ack) begin
            cmd = EV_CLR;
        end
    end

    always_comb begin
        pending_d = pending_q;
        snap_d    = snap_q;
        ovf_d     = ovf_q;

        case (cmd)
            EV_SET: begin
                pending_d = 1'b1;
                snap_d    = i_data;
            end
            EV_CLR:  pending_d = 1'b0;
            default: ;
        endcase

        // A clear coincident with a lost event still counts that event.
        if (i_ovf_clr) begin
            ovf_d = (cmd == EV_OVF) ? CNT_W'(1) : '0;
        end else if (cmd == EV_OVF) begin
            ovf_d = CNT_W'(sat_inc(MAX_CNT_W'(ovf_q), CNT_W));
        end
    end

    // NOTE: the snapshot is a plain flop register, not a RAM, so it takes
    // the reset like the rest of the state; a RAM-backed store could not.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            snap_q    <= '0;
            ovf_q     <= '0;
        end else begin
            pending_q <= pending_d;
            snap_q    <= snap_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_pending = pending_q;
    assign o_snap    = snap_q;
    assign o_ovf_cnt = ovf_q;

endmodule

// File: rtl/bot_evt_sync.sv
// -----------------------------------------------------------------------------
// bot_evt_sync
// Multi-channel event latch with data snapshot between event producers
// (e.g. rojobot31_0) and the CPU GPIO/interrupt inputs.
//   N_CH (1..MAX_CH), DATA_W, CNT_W (1..MAX_CNT_W), SYNC_STAGES, EDGE_MODE
//   clk, rst     - clock, synchronous active-high reset
//   i_evt        - per-channel update strobe / level
//   i_data       - per-channel data, channel k at [k*DATA_W +: DATA_W]
//   i_ack        - per-channel write-1-to-clear of pending
//   i_ovf_clr    - per-channel clear of the overflow counter
//   i_mask       - per-channel interrupt enable
//   o_pending    - registered pending flags
//   o_snap       - registered snapshots, same packing as i_data
//   o_ovf_cnt    - per-channel lost-event counters, channel k at [k*CNT_W +: CNT_W]
//   o_irq        - OR of enabled pending flags
// -----------------------------------------------------------------------------
module bot_evt_sync
    import bot_evt_pkg::*;
#(
    parameter int N_CH        = 1,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        i_evt,
    input  logic [N_CH*DATA_W-1:0] i_data,
    input  logic [N_CH-1:0]        i_ack,
    input  logic [N_CH-1:0]        i_ovf_clr,
    input  logic [N_CH-1:0]        i_mask,
    output logic [N_CH-1:0]        o_pending,
    output logic [N_CH*DATA_W-1:0] o_snap,
    output logic [N_CH*CNT_W-1:0]  o_ovf_cnt,
    output logic                   o_irq
);

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            bot_evt_channel #(
                .DATA_W      (DATA_W),
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE_MODE   (EDGE_MODE)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .i_evt     (i_evt[k]),
                .i_data    (i_data[k*DATA_W +: DATA_W]),
                .i_ack     (i_ack[k]),
                .i_ovf_clr (i_ovf_clr[k]),
                .o_pending (o_pending[k]),
                .o_snap    (o_snap[k*DATA_W +: DATA_W]),
                .o_ovf_cnt (o_ovf_cnt[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Combinational from registers, so the mask takes effect immediately.
    assign o_irq = |(o_pending & i_mask);

endmodule

// File: tb/tb_bot_evt_sync.sv
// -----------------------------------------------------------------------------
// tb_bot_evt_sync
// Three instances:
//   dut_a : 4 ch, 32-bit data, 2-bit counters, 2 sync stages, edge mode;
//           compared every cycle against a reference model, plus directed
//           checks with fixed expected values.
//   dut_b : 1 ch, 16-bit data, 4-bit counter, 2 sync stages, level mode.
//   dut_c : 2 ch, 8-bit data, 3-bit counters, no synchroniser, edge mode.
// -----------------------------------------------------------------------------
module tb_bot_evt_sync;

    localparam int A_N  = 4;
    localparam int A_DW = 32;
    localparam int A_CW = 2;
    localparam int A_S  = 2;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------- dut_a
    logic                rst_a;
    logic [A_N-1:0]      evt_a, ack_a, clr_a, mask_a, pend_a;
    logic [A_N*A_DW-1:0] data_a, snap_a;
    logic [A_N*A_CW-1:0] ovf_a;
    logic                irq_a;

    bot_evt_sync #(.N_CH(A_N), .DATA_W(A_DW), .CNT_W(A_CW),
                   .SYNC_STAGES(A_S), .EDGE_MODE(1)) dut_a (
        .clk(clk), .rst(rst_a), .i_evt(evt_a), .i_data(data_a),
        .i_ack(ack_a), .i_ovf_clr(clr_a), .i_mask(mask_a),
        .o_pending(pend_a), .o_snap(snap_a), .o_ovf_cnt(ovf_a), .o_irq(irq_a)
    );

    // ------------------------------------------------------------- dut_b
    logic        rst_b;
    logic [0:0]  evt_b, ack_b, clr_b, mask_b, pend_b;
    logic [15:0] data_b, snap_b;
    logic [3:0]  ovf_b;
    logic        irq_b;

    bot_evt_sync #(.N_CH(1), .DATA_W(16), .CNT_W(4),
                   .SYNC_STAGES(2), .EDGE_MODE(0)) dut_b (
        .clk(clk), .rst(rst_b), .i_evt(evt_b), .i_data(data_b),
        .i_ack(ack_b), .i_ovf_clr(clr_b), .i_mask(mask_b),
        .o_pending(pend_b), .o_snap(snap_b), .o_ovf_cnt(ovf_b), .o_irq(irq_b)
    );

    // ------------------------------------------------------------- dut_c
    logic        rst_c;
    logic [1:0]  evt_c, ack_c, clr_c, mask_c, pend_c;
    logic [15:0] data_c, snap_c;
    logic [5:0]  ovf_c;
    logic        irq_c;

    bot_evt_sync #(.N_CH(2), .DATA_W(8), .CNT_W(3),
                   .SYNC_STAGES(0), .EDGE_MODE(1)) dut_c (
        .clk(clk), .rst(rst_c), .i_evt(evt_c), .i_data(data_c),
        .i_ack(ack_c), .i_ovf_clr(clr_c), .i_mask(mask_c),
        .o_pending(pend_c), .o_snap(snap_c), .o_ovf_cnt(ovf_c), .o_irq(irq_c)
    );

    // ------------------------------------------------------------- scoring
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------- reference for dut_a
    // Model view: the strobe is sampled at every clock edge after reset.
    // An event is recognised A_S+1 edges after the rising sample, i.e. at
    // edge m an event exists when sample m-A_S is high and sample m-A_S-1 is
    // low, both taken after reset. Rules then apply in priority order.
    logic [A_N-1:0]  m_pend;
    logic [A_DW-1:0] m_snap [A_N];
    int              m_ovf  [A_N];
    logic [A_N-1:0]  hist   [$];

    task automatic model_step();
        logic [A_N-1:0] cur, prv;
        if (rst_a) begin
            m_pend = '0;
            for (int k = 0; k < A_N; k++) begin
                m_snap[k] = '0;
                m_ovf[k]  = 0;
            end
            hist.delete();
        end else begin
            hist.push_front(evt_a);
            if (hist.size() > A_S + 2) void'(hist.pop_back());
            cur = '0;
            prv = '0;
            if (hist.size() == A_S + 2) begin
                cur = hist[A_S];
                prv = hist[A_S+1];
            end
            for (int k = 0; k < A_N; k++) begin
                logic ev, lost;
                ev   = cur[k] & ~prv[k];
                lost = ev & m_pend[k] & ~ack_a[k];
                if (ev && !lost) begin
                    m_pend[k] = 1'b1;
                    m_snap[k] = data_a[k*A_DW +: A_DW];
                end else if (ack_a[k] && !ev) begin
                    m_pend[k] = 1'b0;
                end
                if (clr_a[k]) m_ovf[k] = lost ? 1 : 0;
                else if (lost && m_ovf[k] < (1 << A_CW) - 1) m_ovf[k]++;
            end
        end
    endtask

    task automatic compare_model();
        logic [A_N*A_DW-1:0] esnap;
        logic [A_N*A_CW-1:0] eovf;
        for (int k = 0; k < A_N; k++) begin
            esnap[k*A_DW +: A_DW] = m_snap[k];
            eovf[k*A_CW +: A_CW]  = A_CW'(m_ovf[k]);
        end
        check("model_pending", 128'(pend_a), 128'(m_pend));
        check("model_snap",    128'(snap_a), 128'(esnap));
        check("model_ovf",     128'(ovf_a),  128'(eovf));
        check("model_irq",     128'(irq_a),  128'(|(m_pend & mask_a)));
    endtask

    // One clock: advance the model with the inputs about to be sampled,
    // then look at the DUT 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic pulse_a(input logic [A_N-1:0] ch);
        evt_a = evt_a | ch;
        tick();
        evt_a = evt_a & ~ch;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        rst_a = 1'b1; evt_a = '0; data_a = '0; ack_a = '0; clr_a = '0; mask_a = '0;
        rst_b = 1'b1; evt_b = 1'b1; data_b = 16'h1234; ack_b = '0; clr_b = '0; mask_b = 1'b1;
        rst_c = 1'b1; evt_c = '0; data_c = '0; ack_c = '0; clr_c = '0; mask_c = 2'b10;

        repeat (3) tick();
        check("a_reset_pending", 128'(pend_a), 128'(0));
        check("a_reset_snap",    128'(snap_a), 128'(0));
        check("a_reset_ovf",     128'(ovf_a),  128'(0));
        check("a_reset_irq",     128'(irq_a),  128'(0));
        rst_a = 1'b0;
        tick();

        // single event on ch0, visible on the third edge
        data_a[31:0] = 32'hA5A5_0102;
        mask_a = 4'b0001;
        pulse_a(4'b0001);
        check("single_not_yet", 128'(pend_a), 128'(0));
        tick();
        check("single_pending", 128'(pend_a), 128'(4'b0001));
        check("single_snap",    128'(snap_a[31:0]), 128'(32'hA5A5_0102));
        check("irq_mask1",      128'(irq_a), 128'(1));
        mask_a = 4'b0000;
        #1;
        check("irq_mask0",      128'(irq_a), 128'(0));
        mask_a = 4'b0001;

        // overflow while pending: snapshot frozen, three lost events
        data_a[31:0] = 32'h1111_2222;
        repeat (3) pulse_a(4'b0001);
        repeat (2) tick();
        check("ovf_snap_frozen", 128'(snap_a[31:0]), 128'(32'hA5A5_0102));
        check("ovf_count3",      128'(ovf_a[1:0]), 128'(3));
        ack_a = 4'b0001; tick(); ack_a = '0;
        check("ack_clears",      128'(pend_a), 128'(0));
        clr_a = 4'b0001; tick(); clr_a = '0;
        check("ovf_clr",         128'(ovf_a[1:0]), 128'(0));

        // ack on the very cycle the event is detected re-arms
        data_a[31:0] = 32'h0000_0001;
        pulse_a(4'b0001); tick();
        data_a[31:0] = 32'hBEEF_0003;
        pulse_a(4'b0001);
        ack_a = 4'b0001; tick(); ack_a = '0;
        check("ack_ev_pending", 128'(pend_a), 128'(4'b0001));
        check("ack_ev_snap",    128'(snap_a[31:0]), 128'(32'hBEEF_0003));
        check("ack_ev_ovf",     128'(ovf_a[1:0]), 128'(0));

        // saturation at 3, then clear coincident with a lost event
        repeat (5) pulse_a(4'b0001);
        repeat (2) tick();
        check("sat_count",  128'(ovf_a[1:0]), 128'(3));
        pulse_a(4'b0001);
        clr_a = 4'b0001; tick(); clr_a = '0;
        check("clr_plus_ev", 128'(ovf_a[1:0]), 128'(1));

        // multi-channel masking
        ack_a = 4'b0001; tick(); ack_a = '0;
        mask_a = 4'b0101;
        data_a = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0};
        pulse_a(4'b1010); tick();
        check("multi_pending", 128'(pend_a), 128'(4'b1010));
        check("multi_irq_off", 128'(irq_a), 128'(0));
        pulse_a(4'b0100); tick();
        check("multi_pend_ch2", 128'(pend_a), 128'(4'b1110));
        check("multi_irq_on",   128'(irq_a), 128'(1));
        ack_a = 4'b0100; tick(); ack_a = '0;
        check("multi_ack_ch2",  128'(irq_a), 128'(0));

        // edge mode: level held high through reset is not an event
        evt_a = 4'b1111;
        rst_a = 1'b1; repeat (2) tick(); rst_a = 1'b0;
        repeat (6) tick();
        check("edge_rst_pending", 128'(pend_a), 128'(0));
        check("edge_rst_snap",    128'(snap_a), 128'(0));
        check("edge_rst_ovf",     128'(ovf_a),  128'(0));
        evt_a = '0; tick();
        evt_a = 4'b0001; repeat (3) tick();
        check("edge_after_low",   128'(pend_a), 128'(4'b0001));

        // randomized traffic, with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            rst_a = (c == 200);
            if ($urandom_range(0, 2) == 0) evt_a = A_N'($urandom);
            if ($urandom_range(0, 3) == 0) data_a = {$urandom, $urandom, $urandom, $urandom};
            ack_a = A_N'($urandom) & A_N'($urandom);
            clr_a = ($urandom_range(0, 7) == 0) ? A_N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) mask_a = A_N'($urandom);
            tick();
        end
        rst_a = 1'b0;

        // dut_b, level mode: level high through reset re-arms after release
        check("b_reset_pending", 128'(pend_b), 128'(0));
        check("b_reset_snap",    128'(snap_b), 128'(0));
        rst_b = 1'b0;
        tick();
        check("b_edge1", 128'(pend_b), 128'(0));
        tick();
        check("b_edge2", 128'(pend_b), 128'(0));
        tick();
        check("b_edge3_pending", 128'(pend_b), 128'(1));
        check("b_edge3_snap",    128'(snap_b), 128'(16'h1234));
        check("b_irq",           128'(irq_b),  128'(1));
        data_b = 16'h5678;
        ack_b = 1'b1; tick(); ack_b = 1'b0;
        check("b_ack_rearm",  128'(pend_b), 128'(1));
        check("b_ack_recap",  128'(snap_b), 128'(16'h5678));
        check("b_ack_noovf",  128'(ovf_b),  128'(0));
        tick();
        check("b_level_ovf1", 128'(ovf_b), 128'(1));
        evt_b = 1'b0;
        repeat (4) tick();
        check("b_level_ovf3", 128'(ovf_b), 128'(3));
        ack_b = 1'b1; tick(); ack_b = 1'b0;
        check("b_final_ack",  128'(pend_b), 128'(0));
        check("b_final_irq",  128'(irq_b),  128'(0));

        // dut_c, no synchroniser: one-edge latency
        rst_c = 1'b0;
        tick();
        evt_c = 2'b10; data_c = 16'h3C00;
        tick();
        check("c_pending", 128'(pend_c), 128'(2'b10));
        check("c_snap",    128'(snap_c), 128'(16'h3C00));
        check("c_irq",     128'(irq_c),  128'(1));
        data_c = 16'h7700;
        tick();
        check("c_held_level_snap", 128'(snap_c), 128'(16'h3C00));
        check("c_held_level_ovf",  128'(ovf_c),  128'(0));
        evt_c = 2'b00; tick();
        evt_c = 2'b10; tick();
        check("c_ovf", 128'(ovf_c), 128'(6'b001_000));
        ack_c = 2'b10; evt_c = 2'b00; tick(); ack_c = 2'b00;
        check("c_ack", 128'(pend_c), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
